warp_mem_responder: RTL and testbench
=====================================

Name: warp_mem_responder

Overview:
Responder end of the per-thread data-memory read/write channels driven by the LSUs of a dual-warp core. It accepts requests from NUM_WARPS × THREADS_PER_BLOCK lanes and serializes them onto one external data-memory port using round-robin arbitration. It relays each response back to the requesting lane using the codebase valid/ready channel protocol.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data word width
THREADS_PER_BLOCK, 4, lanes per warp
NUM_WARPS, 2, warps served; lane index = warp*THREADS_PER_BLOCK + thread
(derived) NUM_LANES = NUM_WARPS*THREADS_PER_BLOCK; LANE_BITS = $clog2(NUM_LANES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
consumer_read_valid  in  [NUM_LANES]  lane read request
consumer_read_address  in  [NUM_LANES][ADDR_BITS]  read address
consumer_read_ready  out  [NUM_LANES]  read data valid to lane
consumer_read_data  out  [NUM_LANES][DATA_BITS]  returned data
consumer_write_valid  in  [NUM_LANES]  lane write request
consumer_write_address  in  [NUM_LANES][ADDR_BITS]  write address
consumer_write_data  in  [NUM_LANES][DATA_BITS]  write data
consumer_write_ready  out  [NUM_LANES]  write acknowledged
mem_read_valid  out  1  memory read request
mem_read_address  out  ADDR_BITS  memory read address
mem_read_ready  in  1  memory read data valid
mem_read_data  in  DATA_BITS  memory read data
mem_write_valid  out  1  memory write request
mem_write_address  out  ADDR_BITS
mem_write_data  out  DATA_BITS
mem_write_ready  in  1  memory write acknowledged

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0, including the data buses. state=IDLE, rr_ptr=0, grant latch cleared. An in-flight memory request is abandoned, and the memory model must tolerate that.
- FSM states:
  - IDLE: search lanes starting at rr_ptr, wrapping modulo NUM_LANES. The first lane with read_valid or write_valid and not masked wins.
  - Same-lane conflict: if a lane has read and write both valid, the read wins and the write is served on a later grant.
  - On a grant: latch lane, op, address and data. Next cycle, mem_*_valid=1 and go to READ_WAIT or WRITE_WAIT. Grant-to-mem_valid latency is exactly 1 cycle.
  - READ_WAIT: hold mem_read_valid and mem_read_address stable. When mem_read_ready=1: capture mem_read_data, set mem_read_valid=0, and next cycle drive consumer_read_ready[lane]=1 and consumer_read_data[lane]=data. Go to RELAY.
  - WRITE_WAIT: same as READ_WAIT, using mem_write_ready and consumer_write_ready.
  - RELAY: hold the lane's ready until that lane's matching valid is 0. Then clear ready, set rr_ptr=(lane+1) mod NUM_LANES, and go to IDLE. No new grant occurs in the cycle ready falls.
  - consumer_read_data[lane] holds its last value after ready falls; other lanes' data is unchanged.
- Mask: a lane whose ready is high is never re-granted.
- Minimum read round trip, memory answering same cycle: valid→mem_valid 1 cycle, mem_ready→consumer_ready 1 cycle, release 1 cycle.
- Consumer valid drops during *_WAIT (protocol violation): the memory transaction still completes, ready pulses for exactly 1 cycle, then IDLE.
- No lanes requesting: stay in IDLE, outputs 0, rr_ptr unchanged.
- Only one memory transaction is outstanding at any time; mem_read_valid and mem_write_valid are never both 1.

Decomposition:
- Package mem_responder_pkg holds:
  - state enum {IDLE, READ_WAIT, WRITE_WAIT, RELAY} (2 bits)
  - op enum {OP_READ, OP_WRITE}
  - lane-index width helper function
- One sub-module, rr_arbiter:
  - parameter N
  - inputs req[N], ptr
  - outputs grant_valid, grant_idx
  - purely combinational priority rotation
- The FSM and datapath live in warp_mem_responder.

Test Plan:
- Single read, lane 5, addr 0x3C, memory returns 0xA7 one cycle after request → mem_read_address=0x3C one cycle after valid; consumer_read_ready[5]=1 with data 0xA7; ready clears the cycle after valid drops.
- Single write, lane 2, addr 0x10, data 0x55 → mem_write_valid with 0x10/0x55; consumer_write_ready[2] asserted after mem_write_ready; no read port activity.
- All 8 lanes request reads simultaneously, rr_ptr=0 → grants in order 0,1,…,7 with no lane served twice. A repeat request from lane 0 arrives while lane 7 is in service → lane 0 is served after lane 7 (wrap).
- Lane 3 asserts read and write valid together → read completes first, write granted on a later IDLE pass; mem_*_valid never both high (assertion).
- reset=0 for one cycle while in READ_WAIT → next cycle all outputs 0 and state IDLE; a new request on lane 1 is then served normally, with rr_ptr reset to 0.
- Memory stalls mem_read_ready for 10 cycles → mem_read_valid and address stay stable throughout; no other lane is granted.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the warp memory responder: FSM states, operation kind and
// the lane-index width helper used to size lane pointers.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // A single lane still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins,
// wrapping modulo N.
module rr_arbiter
    import mem_responder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_bits(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    logic [W:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (W+1)'(i);
            if (cand >= (W+1)'(N))
                cand = cand - (W+1)'(N);
            if (!grant_valid && req[cand[W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/warp_mem_responder.sv
// Serializes per-lane LSU read/write requests onto a single data-memory port
// with round-robin arbitration and relays each response back to its lane.
module warp_mem_responder
    import mem_responder_pkg::*;
#(
    parameter  int ADDR_BITS         = 8,
    parameter  int DATA_BITS         = 8,
    parameter  int THREADS_PER_BLOCK = 4,
    parameter  int NUM_WARPS         = 2,
    localparam int NUM_LANES         = NUM_WARPS * THREADS_PER_BLOCK,
    localparam int LANE_BITS         = idx_bits(NUM_LANES)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_LANES-1:0]                  consumer_read_valid,
    input  logic [NUM_LANES-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_LANES-1:0]                  consumer_read_ready,
    output logic [NUM_LANES-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_LANES-1:0]                  consumer_write_valid,
    input  logic [NUM_LANES-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_LANES-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_LANES-1:0]                  consumer_write_ready,
    output logic                                  mem_read_valid,
    output logic [ADDR_BITS-1:0]                  mem_read_address,
    input  logic                                  mem_read_ready,
    input  logic [DATA_BITS-1:0]                  mem_read_data,
    output logic                                  mem_write_valid,
    output logic [ADDR_BITS-1:0]                  mem_write_address,
    output logic [DATA_BITS-1:0]                  mem_write_data,
    input  logic                                  mem_write_ready
);

    state_t                 state, next_state;
    op_t                    op_q;
    logic [LANE_BITS-1:0]   lane_q, rr_ptr, grant_idx;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   wdata_q;
    logic [NUM_LANES-1:0]   rd_rdy, wr_rdy, req;
    logic                   grant_valid, grant_is_read, lane_valid;
    logic                   rd_done, wr_done, release_lane;

    // Lanes already holding ready are excluded so a lane is never re-granted mid-relay.
    assign req = (consumer_read_valid | consumer_write_valid) & ~(rd_rdy | wr_rdy);

    rr_arbiter #(.N(NUM_LANES)) u_arb (
        .req         (req),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Read wins a same-lane conflict; the write stays pending for a later pass.
    assign grant_is_read = consumer_read_valid[grant_idx];
    assign lane_valid    = (op_q == OP_READ) ? consumer_read_valid[lane_q]
                                             : consumer_write_valid[lane_q];
    assign rd_done       = (state == READ_WAIT)  && mem_read_ready;
    assign wr_done       = (state == WRITE_WAIT) && mem_write_ready;
    assign release_lane  = (state == RELAY) && !lane_valid;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (grant_valid) next_state = grant_is_read ? READ_WAIT : WRITE_WAIT;
            READ_WAIT:  if (mem_read_ready) next_state = RELAY;
            WRITE_WAIT: if (mem_write_ready) next_state = RELAY;
            RELAY:      if (!lane_valid) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_read_valid    = 1'b0;
        mem_read_address  = '0;
        mem_write_valid   = 1'b0;
        mem_write_address = '0;
        mem_write_data    = '0;
        case (state)
            READ_WAIT: begin
                mem_read_valid   = 1'b1;
                mem_read_address = addr_q;
            end
            WRITE_WAIT: begin
                mem_write_valid   = 1'b1;
                mem_write_address = addr_q;
                mem_write_data    = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_q  <= '0;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                lane_q  <= grant_idx;
                op_q    <= grant_is_read ? OP_READ : OP_WRITE;
                addr_q  <= grant_is_read ? consumer_read_address[grant_idx]
                                         : consumer_write_address[grant_idx];
                wdata_q <= consumer_write_data[grant_idx];
            end
            if (release_lane)
                rr_ptr <= (lane_q == LANE_BITS'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
        end
    end

    // Per-lane response registers; read data persists after ready falls.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic                 sel, rdy_r, rdy_w;
        logic [DATA_BITS-1:0] dat;

        assign sel = (lane_q == LANE_BITS'(g));

        always_ff @(posedge clk) begin
            if (!reset) begin
                rdy_r <= 1'b0;
                rdy_w <= 1'b0;
                dat   <= '0;
            end else begin
                if (rd_done && sel) begin
                    rdy_r <= 1'b1;
                    dat   <= mem_read_data;
                end else if (release_lane) begin
                    rdy_r <= 1'b0;
                end
                if (wr_done && sel)
                    rdy_w <= 1'b1;
                else if (release_lane)
                    rdy_w <= 1'b0;
            end
        end

        assign rd_rdy[g]             = rdy_r;
        assign wr_rdy[g]             = rdy_w;
        assign consumer_read_data[g] = dat;
    end

    assign consumer_read_ready  = rd_rdy;
    assign consumer_write_ready = wr_rdy;

endmodule

// File: tb/tb_warp_mem_responder.sv
// Directed bench for warp_mem_responder: table of single transactions plus
// hand-written arbitration, conflict, reset and stall sequences.
module tb_warp_mem_responder;

    localparam int NL = 8;

    typedef struct {
        int         lane;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NL-1:0]        consumer_read_valid;
    logic [NL-1:0][7:0]   consumer_read_address;
    logic [NL-1:0]        consumer_read_ready;
    logic [NL-1:0][7:0]   consumer_read_data;
    logic [NL-1:0]        consumer_write_valid;
    logic [NL-1:0][7:0]   consumer_write_address;
    logic [NL-1:0][7:0]   consumer_write_data;
    logic [NL-1:0]        consumer_write_ready;
    logic                 mem_read_valid;
    logic [7:0]           mem_read_address;
    logic                 mem_read_ready;
    logic [7:0]           mem_read_data;
    logic                 mem_write_valid;
    logic [7:0]           mem_write_address;
    logic [7:0]           mem_write_data;
    logic                 mem_write_ready;

    always #5 clk = ~clk;

    warp_mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .THREADS_PER_BLOCK(4), .NUM_WARPS(2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    logic [7:0]    mem_arr [256];
    int            rd_lat, wr_lat, rcnt, wcnt, rd_acks, wr_acks;
    logic [7:0]    last_rd_addr, last_wr_addr, last_wr_data;
    logic [NL-1:0] prev_rr, prev_wr;
    int            log_q[$];
    bit            both_seen;
    int            tests, fails;
    vec_t          vecs[10];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int entry(input int k);
        return (k < log_q.size()) ? log_q[k] : -1;
    endfunction

    // One cycle: sample at negedge, log ready rises, auto-release lanes, model memory.
    task automatic step();
        @(negedge clk);
        if (mem_read_valid && mem_write_valid) both_seen = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (consumer_read_ready[i] && !prev_rr[i]) log_q.push_back(i);
            if (consumer_write_ready[i] && !prev_wr[i]) log_q.push_back(i + 8);
            if (consumer_read_ready[i]) consumer_read_valid[i] = 1'b0;
            if (consumer_write_ready[i]) consumer_write_valid[i] = 1'b0;
        end
        prev_rr = consumer_read_ready;
        prev_wr = consumer_write_ready;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        if (mem_read_valid) begin
            if (rcnt >= rd_lat) begin
                mem_read_ready = 1'b1;
                mem_read_data  = mem_arr[mem_read_address];
                last_rd_addr   = mem_read_address;
                rd_acks++;
                rcnt = 0;
            end else rcnt++;
        end else rcnt = 0;
        if (mem_write_valid) begin
            if (wcnt >= wr_lat) begin
                mem_write_ready = 1'b1;
                mem_arr[mem_write_address] = mem_write_data;
                last_wr_addr = mem_write_address;
                last_wr_data = mem_write_data;
                wr_acks++;
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check({name, "_completed"}, int'(log_q.size() >= n), 1);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int ra = rd_acks;
        int wa = wr_acks;
        string nm = $sformatf("vec%0d", idx);
        log_q.delete();
        if (v.wr) begin
            consumer_write_address[v.lane] = v.addr;
            consumer_write_data[v.lane]    = v.wdata;
            consumer_write_valid[v.lane]   = 1'b1;
        end else begin
            consumer_read_address[v.lane] = v.addr;
            consumer_read_valid[v.lane]   = 1'b1;
        end
        wait_log(1, 40, nm);
        check({nm, "_lane"}, entry(0), v.lane + (v.wr ? 8 : 0));
        if (v.wr) begin
            check({nm, "_wr_addr"}, last_wr_addr, v.addr);
            check({nm, "_wr_data"}, last_wr_data, v.wdata);
            check({nm, "_no_rd"}, rd_acks - ra, 0);
        end else begin
            check({nm, "_rd_addr"}, last_rd_addr, v.addr);
            check({nm, "_rd_data"}, consumer_read_data[v.lane], v.exp_data);
            check({nm, "_no_wr"}, wr_acks - wa, 0);
        end
        step();
        check({nm, "_ready_clear"},
              int'(consumer_read_ready[v.lane] | consumer_write_ready[v.lane]), 0);
        step();
        step();
    endtask

    initial begin
        bit reissued;
        int k;
        tests = 0; fails = 0; both_seen = 1'b0;
        rd_lat = 0; wr_lat = 0; rcnt = 0; wcnt = 0; rd_acks = 0; wr_acks = 0;
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
        prev_rr = '0; prev_wr = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = ~8'(i);
        mem_arr[8'h3C] = 8'hA7;
        reset = 1'b0;
        consumer_read_valid = '0;  consumer_read_address = '0;
        consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;

        vecs[0] = '{3, 1'b0, 8'h3C, 8'h00, 8'hA7};
        vecs[1] = '{2, 1'b1, 8'h10, 8'h55, 8'h00};
        vecs[2] = '{2, 1'b0, 8'h10, 8'h00, 8'h55};
        vecs[3] = '{0, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{7, 1'b1, 8'hFF, 8'h81, 8'h00};
        vecs[5] = '{0, 1'b0, 8'hFF, 8'h00, 8'h81};
        vecs[6] = '{4, 1'b0, 8'h80, 8'h00, 8'h7F};
        vecs[7] = '{1, 1'b1, 8'h3C, 8'h5A, 8'h00};
        vecs[8] = '{6, 1'b0, 8'h3C, 8'h00, 8'h5A};
        vecs[9] = '{7, 1'b0, 8'hFF, 8'h00, 8'h81};

        step(); step();
        check("rst_mem_rd_valid", mem_read_valid, 0);
        check("rst_mem_wr_valid", mem_write_valid, 0);
        check("rst_mem_buses", int'({mem_read_address, mem_write_address, mem_write_data}), 0);
        check("rst_cons_ready", int'({consumer_read_ready, consumer_write_ready}), 0);
        check("rst_cons_data_zero", int'(consumer_read_data == '0), 1);
        reset = 1'b1;
        step();

        // Lane 5 read with cycle-exact latency checks; memory answers one cycle late.
        rd_lat = 1;
        consumer_read_address[5] = 8'h3C;
        consumer_read_valid[5]   = 1'b1;
        step();
        check("rd5_mem_valid", mem_read_valid, 1);
        check("rd5_mem_addr", mem_read_address, 8'h3C);
        check("rd5_no_early_ready", consumer_read_ready, 0);
        step();
        check("rd5_wait_ready_low", consumer_read_ready, 0);
        step();
        check("rd5_ready", consumer_read_ready, 8'h20);
        check("rd5_data", consumer_read_data[5], 8'hA7);
        check("rd5_mem_valid_low", mem_read_valid, 0);
        step();
        check("rd5_ready_clear", consumer_read_ready, 0);
        check("rd5_data_hold", consumer_read_data[5], 8'hA7);
        step();

        rd_lat = 0;
        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // All lanes read at once from rr_ptr 0; lane 0 re-requests while lane 7 is served.
        log_q.delete();
        for (int i = 0; i < NL; i++) begin
            consumer_read_address[i] = 8'(i * 16);
            consumer_read_valid[i]   = 1'b1;
        end
        reissued = 1'b0;
        k = 0;
        while (log_q.size() < 9 && k < 300) begin
            step();
            k++;
            if (!reissued && mem_read_valid && mem_read_address == 8'h70) begin
                consumer_read_address[0] = 8'h01;
                consumer_read_valid[0]   = 1'b1;
                reissued = 1'b1;
            end
        end
        check("rr_completed", int'(log_q.size() >= 9), 1);
        for (int i = 0; i < 9; i++)
            check($sformatf("rr_order%0d", i), entry(i), i % 8);
        check("rr_wrap_addr", last_rd_addr, 8'h01);
        step(); step(); step();

        // Read and write valid together on lane 3: read first, write on a later pass.
        log_q.delete();
        consumer_read_address[3]  = 8'h20;
        consumer_write_address[3] = 8'h21;
        consumer_write_data[3]    = 8'h99;
        consumer_read_valid[3]    = 1'b1;
        consumer_write_valid[3]   = 1'b1;
        wait_log(2, 60, "conflict");
        check("conflict_first_read", entry(0), 3);
        check("conflict_then_write", entry(1), 11);
        check("conflict_wr_addr", last_wr_addr, 8'h21);
        check("conflict_wr_data", last_wr_data, 8'h99);
        step(); step(); step();

        // Reset pulse while a read is stalled in flight.
        rd_lat = 20;
        log_q.delete();
        consumer_read_address[6] = 8'h40;
        consumer_read_valid[6]   = 1'b1;
        k = 0;
        while (!mem_read_valid && k < 5) begin step(); k++; end
        check("rstmid_in_wait", mem_read_valid, 1);
        step();
        consumer_read_valid[6] = 1'b0;
        reset = 1'b0;
        step();
        check("rstmid_mem_valid", int'({mem_read_valid, mem_write_valid}), 0);
        check("rstmid_mem_buses", int'({mem_read_address, mem_write_address, mem_write_data}), 0);
        check("rstmid_cons_ready", int'({consumer_read_ready, consumer_write_ready}), 0);
        check("rstmid_cons_data_zero", int'(consumer_read_data == '0), 1);
        reset = 1'b1;
        rd_lat = 0;
        consumer_read_address[1] = 8'h11;
        consumer_read_address[5] = 8'h55;
        consumer_read_valid[1]   = 1'b1;
        consumer_read_valid[5]   = 1'b1;
        wait_log(2, 60, "post_rst");
        check("post_rst_first", entry(0), 1);
        check("post_rst_second", entry(1), 5);
        step(); step(); step();

        // Memory stalls 10 cycles: request held stable, nothing else granted.
        rd_lat = 10;
        log_q.delete();
        consumer_read_address[2] = 8'h33;
        consumer_read_address[4] = 8'h44;
        consumer_read_valid[2]   = 1'b1;
        consumer_read_valid[4]   = 1'b1;
        k = 0;
        while (!mem_read_valid && k < 5) begin step(); k++; end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d_valid", i), mem_read_valid, 1);
            check($sformatf("stall%0d_addr", i), mem_read_address, 8'h33);
            check($sformatf("stall%0d_no_ready", i), consumer_read_ready, 0);
            step();
        end
        wait_log(2, 80, "stall");
        check("stall_first", entry(0), 2);
        check("stall_second", entry(1), 4);
        check("stall_data2", consumer_read_data[2], 8'hCC);
        check("stall_data4", consumer_read_data[4], 8'hBB);
        step(); step();

        check("rd_wr_never_both", int'(both_seen), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
